ysyx_22050854_mem_stage: RTL and testbench



---
 rtl/ysyx_22050854_mem_stage.sv | 176 +++++++++++++++++
 tb/tb_ysyx_22050854_mem_stage.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050854_mem_stage.sv
// Memory-access stage: accepts one instruction at a time from execute and runs
// loads/stores over a single-outstanding req/ack port, then retires to write-back.
module ysyx_22050854_mem_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        RegWr,
  input  logic [2:0]  funct3,
  input  logic [63:0] alu_out,
  input  logic [63:0] store_data,
  input  logic [4:0]  rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_MemtoReg,
  output logic        wb_RegWr,
  output logic [63:0] wb_alu_out,
  output logic [63:0] wb_mem_data,
  output logic [4:0]  wb_rd,
  output logic        misalign
);

  typedef enum logic {IDLE, BUS} state_t;

  state_t state, state_nxt;

  logic        accept;
  logic        is_mem;
  logic        mis_now;
  logic [2:0]  in_off;
  logic [1:0]  in_size;
  logic [7:0]  lane_mask;
  logic [63:0] lane_data;

  logic [2:0]  p_funct3;
  logic [2:0]  p_off;
  logic        p_load;
  logic [63:0] p_alu_out;
  logic [4:0]  p_rd;
  logic        p_memtoreg;
  logic        p_regwr;

  logic [63:0] rd_shifted;
  logic [63:0] load_ext;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;
  assign is_mem   = MemRead | MemWrite;
  assign in_off   = alu_out[2:0];
  // funct3[1:0] encodes the access size for every code, so 111 falls into D.
  assign in_size  = funct3[1:0];

  always_comb begin
    mis_now = 1'b0;
    if (is_mem) begin
      case (in_size)
        2'b01:   mis_now = in_off[0];
        2'b10:   mis_now = (in_off[1:0] != 2'b00);
        2'b11:   mis_now = (in_off != 3'b000);
        default: mis_now = 1'b0;
      endcase
    end
  end

  always_comb begin
    lane_mask = 8'hFF;
    case (in_size)
      2'b00:   lane_mask = 8'h01 << in_off;
      2'b01:   lane_mask = 8'h03 << in_off;
      2'b10:   lane_mask = 8'h0F << in_off;
      default: lane_mask = 8'hFF;
    endcase
  end

  assign lane_data  = store_data << {in_off, 3'b000};
  assign rd_shifted = mem_rdata >> {p_off, 3'b000};

  always_comb begin
    load_ext = rd_shifted;
    case (p_funct3)
      3'b000:  load_ext = {{56{rd_shifted[7]}},  rd_shifted[7:0]};
      3'b001:  load_ext = {{48{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b010:  load_ext = {{32{rd_shifted[31]}}, rd_shifted[31:0]};
      3'b100:  load_ext = {56'd0, rd_shifted[7:0]};
      3'b101:  load_ext = {48'd0, rd_shifted[15:0]};
      3'b110:  load_ext = {32'd0, rd_shifted[31:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_mem && !mis_now) state_nxt = BUS;
      BUS:     if (mem_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus registers, pending instruction fields and write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 64'd0;
      mem_wdata   <= 64'd0;
      mem_wmask   <= 8'd0;
      wb_valid    <= 1'b0;
      wb_MemtoReg <= 1'b0;
      wb_RegWr    <= 1'b0;
      wb_alu_out  <= 64'd0;
      wb_mem_data <= 64'd0;
      wb_rd       <= 5'd0;
      misalign    <= 1'b0;
      p_funct3    <= 3'd0;
      p_off       <= 3'd0;
      p_load      <= 1'b0;
      p_alu_out   <= 64'd0;
      p_rd        <= 5'd0;
      p_memtoreg  <= 1'b0;
      p_regwr     <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      if (state == IDLE) begin
        if (accept) begin
          if (!is_mem || mis_now) begin
            wb_valid    <= 1'b1;
            misalign    <= mis_now;
            wb_MemtoReg <= MemtoReg;
            wb_RegWr    <= RegWr & ~mis_now;
            wb_alu_out  <= alu_out;
            wb_rd       <= rd;
            wb_mem_data <= 64'd0;
          end else begin
            mem_req    <= 1'b1;
            mem_we     <= MemWrite;
            mem_addr   <= {alu_out[63:3], 3'b000};
            mem_wdata  <= lane_data;
            mem_wmask  <= lane_mask;
            p_funct3   <= funct3;
            p_off      <= in_off;
            p_load     <= MemRead & ~MemWrite;
            p_alu_out  <= alu_out;
            p_rd       <= rd;
            p_memtoreg <= MemtoReg;
            p_regwr    <= RegWr;
          end
        end
      end else if (mem_ack) begin
        mem_req     <= 1'b0;
        wb_valid    <= 1'b1;
        wb_MemtoReg <= p_memtoreg;
        wb_RegWr    <= p_regwr;
        wb_alu_out  <= p_alu_out;
        wb_rd       <= p_rd;
        wb_mem_data <= p_load ? load_ext : 64'd0;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22050854_mem_stage.sv
// Randomized bench for the memory stage, checked against a byte-addressed memory
// model and per-instruction expectations derived from access size and address.
module tb_ysyx_22050854_mem_stage;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        MemRead;
  logic        MemWrite;
  logic        MemtoReg;
  logic        RegWr;
  logic [2:0]  funct3;
  logic [63:0] alu_out;
  logic [63:0] store_data;
  logic [4:0]  rd;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        wb_valid;
  logic        wb_MemtoReg;
  logic        wb_RegWr;
  logic [63:0] wb_alu_out;
  logic [63:0] wb_mem_data;
  logic [4:0]  wb_rd;
  logic        misalign;

  int total;
  int bad;
  logic [7:0] mem_bytes [0:255];

  ysyx_22050854_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWr(RegWr),
    .funct3(funct3), .alu_out(alu_out), .store_data(store_data), .rd(rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_MemtoReg(wb_MemtoReg), .wb_RegWr(wb_RegWr),
    .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .wb_rd(wb_rd),
    .misalign(misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2, 3'd6: return 4;
      default:    return 8;
    endcase
  endfunction

  function automatic logic [63:0] dword_at(input logic [63:0] addr);
    logic [63:0] v;
    logic [7:0]  idx;
    v = 64'd0;
    for (int i = 0; i < 8; i++) begin
      idx = 8'((addr & ~64'd7) + 64'(i));
      v = v | (64'(mem_bytes[idx]) << (8 * i));
    end
    return v;
  endfunction

  // Little-endian read of size bytes at addr, sign-extended unless an unsigned code.
  function automatic logic [63:0] ref_load(input logic [63:0] addr, input logic [2:0] f3);
    logic [63:0] v;
    logic [7:0]  idx;
    int          n;
    n = size_of(f3);
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      idx = 8'(addr + 64'(i));
      v = v | (64'(mem_bytes[idx]) << (8 * i));
    end
    if (n < 8 && !(f3 == 3'd4 || f3 == 3'd5 || f3 == 3'd6) && v[8 * n - 1])
      v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  task automatic applyStimulus(input logic mr, input logic mw, input logic m2r, input logic rw,
                               input logic [2:0] f3, input logic [63:0] addr,
                               input logic [63:0] sdata, input logic [4:0] rdi, input int waits);
    int          n, off;
    bit          bus, mis, is_load;
    logic [7:0]  exp_mask;
    logic [63:0] exp_wdata, exp_load;
    logic [7:0]  idx;
    n         = size_of(f3);
    off       = int'(addr % 64'd8);
    bus       = (mr || mw) && (addr % 64'(n) == 64'd0);
    mis       = (mr || mw) && !bus;
    is_load   = mr && !mw;
    exp_mask  = (n == 8) ? 8'hFF : 8'(((1 << n) - 1) << off);
    exp_wdata = sdata << (8 * off);
    exp_load  = ref_load(addr, f3);

    MemRead = mr; MemWrite = mw; MemtoReg = m2r; RegWr = rw;
    funct3 = f3; alu_out = addr; store_data = sdata; rd = rdi;
    in_valid = 1'b1;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    checkOutput("in_ready_idle", 64'(in_ready), 64'd1);
    checkOutput("wb_valid_idle", 64'(wb_valid), 64'd0);
    checkOutput("mem_req_idle", 64'(mem_req), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mem_ack = 1'b0;
    alu_out = {$urandom, $urandom};
    store_data = {$urandom, $urandom};

    if (bus) begin
      for (int k = 0; k <= waits; k++) begin
        mem_ack   = (k == waits);
        mem_rdata = (k == waits) ? dword_at(addr) : {$urandom, $urandom};
        @(negedge clk);
        checkOutput("mem_req_bus", 64'(mem_req), 64'd1);
        checkOutput("in_ready_bus", 64'(in_ready), 64'd0);
        checkOutput("wb_valid_bus", 64'(wb_valid), 64'd0);
        checkOutput("mem_addr", mem_addr, addr & ~64'd7);
        checkOutput("mem_we", 64'(mem_we), 64'(mw));
        if (mw) begin
          checkOutput("mem_wmask", 64'(mem_wmask), 64'(exp_mask));
          checkOutput("mem_wdata", mem_wdata, exp_wdata);
        end
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
      end
      if (mw) begin
        for (int i = 0; i < n; i++) begin
          idx = 8'(addr + 64'(i));
          mem_bytes[idx] = sdata[8 * i +: 8];
        end
      end
    end

    @(negedge clk);
    checkOutput("wb_valid", 64'(wb_valid), 64'd1);
    checkOutput("misalign", 64'(misalign), 64'(mis));
    checkOutput("wb_RegWr", 64'(wb_RegWr), 64'(rw && !mis));
    checkOutput("wb_MemtoReg", 64'(wb_MemtoReg), 64'(m2r));
    checkOutput("wb_alu_out", wb_alu_out, addr);
    checkOutput("wb_rd", 64'(wb_rd), 64'(rdi));
    checkOutput("mem_req_retire", 64'(mem_req), 64'd0);
    checkOutput("in_ready_retire", 64'(in_ready), 64'd1);
    if (!mr && !mw) checkOutput("wb_mem_data_alu", wb_mem_data, 64'd0);
    if (bus && is_load) checkOutput("wb_mem_data_load", wb_mem_data, exp_load);
    @(posedge clk);
    #1;
  endtask

  logic [63:0] exp_ld;

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWr = 1'b0;
    funct3 = 3'd0; alu_out = 64'd0; store_data = 64'd0; rd = 5'd0;
    mem_ack = 1'b0; mem_rdata = 64'd0;
    for (int i = 0; i < 256; i++) mem_bytes[i] = 8'($urandom);

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", 64'(mem_req), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_mem_addr", mem_addr, 64'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 64'd0);
    checkOutput("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wb_alu_out", wb_alu_out, 64'd0);
    checkOutput("rst_wb_mem_data", wb_mem_data, 64'd0);
    checkOutput("rst_misalign", 64'(misalign), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;

    // Directed cases from the test plan.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 64'h1234, 64'd0, 5'd5, 0);
    for (int i = 0; i < 8; i++) mem_bytes[i] = 8'h00;
    mem_bytes[3] = 8'h80;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd0, 64'h1003, 64'd0, 5'd7, 3);
    checkOutput("lb_const", wb_mem_data, 64'hFFFF_FFFF_FFFF_FF80);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 64'h1003, 64'd0, 5'd7, 1);
    checkOutput("lbu_const", wb_mem_data, 64'h80);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 64'h2006, 64'hBEEF, 5'd0, 2);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 64'h3002, 64'd0, 5'd3, 0);

    // Reset asserted while a load is waiting for its ack.
    MemRead = 1'b1; MemWrite = 1'b0; MemtoReg = 1'b1; RegWr = 1'b1;
    funct3 = 3'd3; alu_out = 64'h40; rd = 5'd9; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort_req_before", 64'(mem_req), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_req_async", 64'(mem_req), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = dword_at(64'h40);
    @(negedge clk);
    checkOutput("abort_in_ready", 64'(in_ready), 64'd1);
    checkOutput("abort_no_wb", 64'(wb_valid), 64'd0);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("abort_no_wb_late", 64'(wb_valid), 64'd0);
    checkOutput("abort_req_late", 64'(mem_req), 64'd0);
    @(posedge clk);
    #1;

    // ALU, LD with zero-wait ack, ALU back to back.
    MemRead = 1'b0; MemWrite = 1'b0; MemtoReg = 1'b0; RegWr = 1'b1;
    funct3 = 3'd0; alu_out = 64'h1234; rd = 5'd5; in_valid = 1'b1;
    @(posedge clk);
    #1;
    MemRead = 1'b1; MemtoReg = 1'b1; funct3 = 3'd3; alu_out = 64'h48; rd = 5'd9;
    exp_ld = ref_load(64'h48, 3'd3);
    @(negedge clk);
    checkOutput("b2b_wb1", 64'(wb_valid), 64'd1);
    checkOutput("b2b_alu1", wb_alu_out, 64'h1234);
    checkOutput("b2b_rd1", 64'(wb_rd), 64'd5);
    checkOutput("b2b_ready1", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemtoReg = 1'b0; funct3 = 3'd0; alu_out = 64'h5678; rd = 5'd11;
    mem_ack = 1'b1;
    mem_rdata = dword_at(64'h48);
    @(negedge clk);
    checkOutput("b2b_ready_bus", 64'(in_ready), 64'd0);
    checkOutput("b2b_req", 64'(mem_req), 64'd1);
    checkOutput("b2b_wb_gap", 64'(wb_valid), 64'd0);
    checkOutput("b2b_addr", mem_addr, 64'h48);
    @(posedge clk);
    #1;
    mem_ack = 1'b0;
    @(negedge clk);
    checkOutput("b2b_wb2", 64'(wb_valid), 64'd1);
    checkOutput("b2b_ld_data", wb_mem_data, exp_ld);
    checkOutput("b2b_rd2", 64'(wb_rd), 64'd9);
    checkOutput("b2b_ready2", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b_wb3", 64'(wb_valid), 64'd1);
    checkOutput("b2b_alu3", wb_alu_out, 64'h5678);
    checkOutput("b2b_rd3", 64'(wb_rd), 64'd11);
    checkOutput("b2b_memdata3", wb_mem_data, 64'd0);
    @(posedge clk);
    #1;

    // Random mix of ALU ops, loads, stores and misaligned accesses.
    for (int t = 0; t < 150; t++) begin
      logic mr, mw;
      logic [63:0] a;
      int kind;
      kind = int'($urandom_range(0, 3));
      mr = (kind == 1) || (kind == 3 && $urandom_range(0, 1) == 1);
      mw = (kind == 2) || (kind == 3);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) a[2:0] = 3'd0;
      applyStimulus(mr, mw, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    3'($urandom_range(0, 7)), a, {$urandom, $urandom},
                    5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
